// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch FIFO between program-memory fetch and decode_stage.
// Holds fetched words with their PCs so fetch can keep running while decode stalls.
//
// Ports:
//   clk, init                  divided core clock; synchronous active-high reset
//   fetch_valid/inst/pc        word from program memory; fetch_ready = room for it
//   decode_ready               decode consumes the head this cycle (low = stall)
//   inst_valid/inst_out/pc_out head of queue; NOP_INST / 16'h0000 when empty
//   flush                      control-flow redirect; drops every entry
//   level                      occupancy, 0..DEPTH
//
// Optional feature: define PREFETCH_BYPASS_EN to forward a fetch word straight to
// the head ports when the queue is empty (zero-latency path). Undefined by default.

module fetch_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] NOP_INST = 16'h4C00
) (
    input  logic                     clk,
    input  logic                     init,
    input  logic                     fetch_valid,
    input  logic [15:0]              fetch_inst,
    input  logic [15:0]              fetch_pc,
    output logic                     fetch_ready,
    input  logic                     decode_ready,
    output logic                     inst_valid,
    output logic [15:0]              inst_out,
    output logic [15:0]              pc_out,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    typedef struct packed {
        logic [15:0] inst;
        logic [15:0] pc;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] level_q;

    logic   q_valid;
    logic   bypass_hit;
    logic   bypass_take;
    logic   push;
    logic   pop;
    entry_t head;

    assign level   = level_q;
    assign q_valid = (level_q != '0);
    assign head    = mem[rd_ptr];

`ifdef PREFETCH_BYPASS_EN
    // Empty queue: present the incoming fetch word directly on the head ports.
    assign bypass_hit = ~q_valid & fetch_valid & ~flush;
`else
    assign bypass_hit = 1'b0;
`endif

    // A bypassed word that decode accepts is consumed without being stored.
    assign bypass_take = bypass_hit & decode_ready;

    // Full queue refuses a push even if a pop happens in the same cycle.
    assign fetch_ready = (level_q != FULL);

    assign push = fetch_valid & fetch_ready & ~flush & ~bypass_take;
    assign pop  = q_valid & decode_ready & ~flush;

    always_comb begin
        inst_valid = q_valid | bypass_hit;
        inst_out   = NOP_INST;
        pc_out     = 16'h0000;
        if (q_valid) begin
            inst_out = head.inst;
            pc_out   = head.pc;
        end else if (bypass_hit) begin
            inst_out = fetch_inst;
            pc_out   = fetch_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (init) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage is not reset; level alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push && !init) begin
            mem[wr_ptr] <= '{inst: fetch_inst, pc: fetch_pc};
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed testbench for fetch_prefetch_queue.
// Inputs change 1 time unit after posedge; outputs are sampled there too.

module tb_fetch_prefetch_queue;

    logic        clk;
    logic        init;
    logic        fetch_valid;
    logic [15:0] fetch_inst;
    logic [15:0] fetch_pc;
    logic        fetch_ready;
    logic        decode_ready;
    logic        inst_valid;
    logic [15:0] inst_out;
    logic [15:0] pc_out;
    logic        flush;
    logic [2:0]  level;

    int checks;
    int failures;

    fetch_prefetch_queue dut (
        .clk          (clk),
        .init         (init),
        .fetch_valid  (fetch_valid),
        .fetch_inst   (fetch_inst),
        .fetch_pc     (fetch_pc),
        .fetch_ready  (fetch_ready),
        .decode_ready (decode_ready),
        .inst_valid   (inst_valid),
        .inst_out     (inst_out),
        .pc_out       (pc_out),
        .flush        (flush),
        .level        (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        init = 1'b1;
        fetch_valid = 1'b1;
        fetch_inst = 16'hDEAD;
        fetch_pc = 16'h0050;
        decode_ready = 1'b0;
        flush = 1'b0;
        step();
        step();
        init = 1'b0;
        fetch_valid = 1'b0;
        #1;
        checks++;
        if (level !== 3'd0) begin
            failures++;
            $display("FAIL reset_level got=%0d exp=0", level);
        end
        checks++;
        if (inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b exp=0", inst_valid);
        end
        checks++;
        if (inst_out !== 16'h4C00) begin
            failures++;
            $display("FAIL reset_inst got=%h exp=4c00", inst_out);
        end
        checks++;
        if (pc_out !== 16'h0000) begin
            failures++;
            $display("FAIL reset_pc got=%h exp=0000", pc_out);
        end
        checks++;
        if (fetch_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=1", fetch_ready);
        end
    endtask

    task automatic test_empty_pop();
        decode_ready = 1'b1;
        fetch_valid = 1'b0;
        step();
        step();
        checks++;
        if (level !== 3'd0 || inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL empty_pop level=%0d valid=%b exp 0/0", level, inst_valid);
        end
        decode_ready = 1'b0;
    endtask

    task automatic test_fill();
        logic [15:0] w [4];
        w[0] = 16'h1111;
        w[1] = 16'h2222;
        w[2] = 16'h3333;
        w[3] = 16'h4444;
        decode_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fetch_valid = 1'b1;
            fetch_inst = w[i];
            fetch_pc = 16'h0100 + 16'(2 * i);
            step();
            checks++;
            if (level !== 3'(i + 1)) begin
                failures++;
                $display("FAIL fill_level%0d got=%0d exp=%0d", i, level, i + 1);
            end
        end
        checks++;
        if (fetch_ready !== 1'b0) begin
            failures++;
            $display("FAIL fill_ready got=%b exp=0", fetch_ready);
        end
        fetch_inst = 16'h5555;
        fetch_pc = 16'h0108;
        step();
        checks++;
        if (level !== 3'd4) begin
            failures++;
            $display("FAIL full_refuse_level got=%0d exp=4", level);
        end
        checks++;
        if (inst_out !== 16'h1111 || pc_out !== 16'h0100) begin
            failures++;
            $display("FAIL full_head got=%h@%h exp=1111@0100", inst_out, pc_out);
        end
    endtask

    task automatic test_full_push_pop();
        logic [15:0] w [3];
        w[0] = 16'h2222;
        w[1] = 16'h3333;
        w[2] = 16'h4444;
        fetch_valid = 1'b1;
        fetch_inst = 16'h5555;
        fetch_pc = 16'h0108;
        decode_ready = 1'b1;
        step();
        fetch_valid = 1'b0;
        decode_ready = 1'b0;
        #1;
        checks++;
        if (level !== 3'd3) begin
            failures++;
            $display("FAIL fpp_level got=%0d exp=3", level);
        end
        decode_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (inst_out !== w[i] || pc_out !== 16'h0102 + 16'(2 * i) || inst_valid !== 1'b1) begin
                failures++;
                $display("FAIL fpp_drain%0d got=%h@%h v=%b exp=%h@%h", i, inst_out, pc_out, inst_valid, w[i], 16'h0102 + 16'(2 * i));
            end
            step();
        end
        checks++;
        if (inst_valid !== 1'b0 || inst_out !== 16'h4C00 || level !== 3'd0) begin
            failures++;
            $display("FAIL fpp_empty got v=%b %h lvl=%0d exp 0 4c00 0", inst_valid, inst_out, level);
        end
        decode_ready = 1'b0;
    endtask

    task automatic test_wrap();
        int sent;
        int got;
        int cyc;
        logic acc;
        logic con;
        sent = 0;
        got = 0;
        cyc = 0;
        while (got < 10 && cyc < 60) begin
            fetch_valid = (sent < 10);
            fetch_inst = 16'h2000 + 16'(sent);
            fetch_pc = 16'h0200 + 16'(2 * sent);
            decode_ready = (cyc % 2 == 0);
            #1;
            acc = fetch_valid & fetch_ready;
            con = inst_valid & decode_ready;
            if (con) begin
                checks++;
                if (inst_out !== 16'h2000 + 16'(got) || pc_out !== 16'h0200 + 16'(2 * got)) begin
                    failures++;
                    $display("FAIL wrap_word%0d got=%h@%h exp=%h@%h", got, inst_out, pc_out, 16'h2000 + 16'(got), 16'h0200 + 16'(2 * got));
                end
                got++;
            end
            if (level > 3'd4) begin
                failures++;
                $display("FAIL wrap_level got=%0d exp<=4", level);
            end
            if (acc) sent++;
            step();
            cyc++;
        end
        fetch_valid = 1'b0;
        decode_ready = 1'b0;
        #1;
        checks++;
        if (got !== 10 || level !== 3'd0) begin
            failures++;
            $display("FAIL wrap_done got=%0d words lvl=%0d exp=10 words lvl=0", got, level);
        end
    endtask

    task automatic test_flush();
        decode_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fetch_valid = 1'b1;
            fetch_inst = 16'h7000 + 16'(i);
            fetch_pc = 16'h0280 + 16'(2 * i);
            step();
        end
        checks++;
        if (level !== 3'd3) begin
            failures++;
            $display("FAIL flush_pre_level got=%0d exp=3", level);
        end
        fetch_inst = 16'hBEEF;
        fetch_pc = 16'h02F0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        fetch_valid = 1'b0;
        #1;
        checks++;
        if (level !== 3'd0 || inst_valid !== 1'b0 || inst_out !== 16'h4C00 || pc_out !== 16'h0000) begin
            failures++;
            $display("FAIL flush_state lvl=%0d v=%b %h@%h exp 0 0 4c00@0000", level, inst_valid, inst_out, pc_out);
        end
        fetch_valid = 1'b1;
        fetch_inst = 16'h0A0A;
        fetch_pc = 16'h0300;
        step();
        fetch_valid = 1'b0;
        #1;
        checks++;
        if (inst_valid !== 1'b1 || inst_out !== 16'h0A0A || pc_out !== 16'h0300 || level !== 3'd1) begin
            failures++;
            $display("FAIL flush_next v=%b %h@%h lvl=%0d exp 1 0a0a@0300 1", inst_valid, inst_out, pc_out, level);
        end
        decode_ready = 1'b1;
        step();
        decode_ready = 1'b0;
        #1;
        checks++;
        if (inst_valid !== 1'b0 || level !== 3'd0) begin
            failures++;
            $display("FAIL flush_drain v=%b lvl=%0d exp 0 0", inst_valid, level);
        end
    endtask

    task automatic test_init_flush();
        decode_ready = 1'b0;
        fetch_valid = 1'b1;
        fetch_inst = 16'h1234;
        fetch_pc = 16'h0310;
        step();
        step();
        init = 1'b1;
        flush = 1'b1;
        step();
        init = 1'b0;
        flush = 1'b0;
        fetch_valid = 1'b0;
        #1;
        checks++;
        if (level !== 3'd0 || inst_valid !== 1'b0 || fetch_ready !== 1'b1) begin
            failures++;
            $display("FAIL init_flush lvl=%0d v=%b rdy=%b exp 0 0 1", level, inst_valid, fetch_ready);
        end
    endtask

    task automatic test_bypass();
        fetch_valid = 1'b1;
        fetch_inst = 16'h6C01;
        fetch_pc = 16'h0400;
        decode_ready = 1'b1;
        #1;
`ifdef PREFETCH_BYPASS_EN
        checks++;
        if (inst_valid !== 1'b1 || inst_out !== 16'h6C01 || pc_out !== 16'h0400) begin
            failures++;
            $display("FAIL bypass_same v=%b %h@%h exp 1 6c01@0400", inst_valid, inst_out, pc_out);
        end
        step();
        fetch_valid = 1'b0;
        #1;
        checks++;
        if (level !== 3'd0 || inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL bypass_after lvl=%0d v=%b exp 0 0", level, inst_valid);
        end
`else
        checks++;
        if (inst_valid !== 1'b0 || inst_out !== 16'h4C00) begin
            failures++;
            $display("FAIL nobypass_same v=%b %h exp 0 4c00", inst_valid, inst_out);
        end
        step();
        fetch_valid = 1'b0;
        #1;
        checks++;
        if (inst_valid !== 1'b1 || inst_out !== 16'h6C01 || pc_out !== 16'h0400 || level !== 3'd1) begin
            failures++;
            $display("FAIL nobypass_next v=%b %h@%h lvl=%0d exp 1 6c01@0400 1", inst_valid, inst_out, pc_out, level);
        end
        step();
        checks++;
        if (level !== 3'd0 || inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL nobypass_drain lvl=%0d v=%b exp 0 0", level, inst_valid);
        end
`endif
        decode_ready = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        init = 1'b0;
        flush = 1'b0;
        fetch_valid = 1'b0;
        fetch_inst = 16'h0000;
        fetch_pc = 16'h0000;
        decode_ready = 1'b0;
        #2;
        test_reset();
        test_empty_pop();
        test_fill();
        test_full_push_pop();
        test_wrap();
        test_flush();
        test_init_flush();
        test_bypass();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
